pic_bus_buffer_ctl: RTL and testbench

Clocked, parametrised successor to the PIC's 8-bit data bus buffer. It sits between the host CPU bus (CS_n/RD_n/WR_n/A0/D) and the PIC's internal control logic.
- Host strobes are synchronised, and host writes are captured into a small write FIFO drained by a valid/ready handshake.
- Host reads run through a request/hold-register state machine.
- Bus-direction control is explicit (d_out/d_oe), never inferred from a level-sensitive latch.

---
 rtl/pic_bus_pkg.sv | 18 +
 rtl/pic_bus_wfifo.sv | 65 ++++++
 rtl/pic_bus_buffer_ctl.sv | 167 ++++++++++++++++
 tb/tb_pic_bus_buffer_ctl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_bus_pkg.sv
// Shared types and constants for the PIC host bus buffer and its write FIFO.
package pic_bus_pkg;

    localparam int unsigned DefDataW = 8;
    localparam int unsigned DefDepth = 4;

    typedef enum logic [1:0] {
        R_IDLE,
        R_REQ,
        R_DRIVE
    } rd_state_e;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int unsigned level_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pic_bus_wfifo.sv
// Circular-buffer FIFO with push/pop, full/empty and occupancy; head is read combinationally.
module pic_bus_wfifo
    import pic_bus_pkg::*;
#(
    parameter int unsigned Width = 9,
    parameter int unsigned Depth = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        push_i,
    input  logic [Width-1:0]            data_i,
    input  logic                        pop_i,
    output logic [Width-1:0]            data_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [level_w(Depth)-1:0]   level_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = level_w(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LvlW-1:0]  level_q, level_d;
    logic             push_acc, pop_acc;

    assign full_o   = (level_q == LvlW'(Depth));
    assign empty_o  = (level_q == '0);
    assign level_o  = level_q;
    assign data_o   = mem_q[rptr_q];

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign push_acc = push_i & (~full_o | pop_i);
    assign pop_acc  = pop_i & ~empty_o;

    always_comb begin
        wptr_d  = push_acc ? wptr_q + PtrW'(1) : wptr_q;
        rptr_d  = pop_acc ? rptr_q + PtrW'(1) : rptr_q;
        level_d = level_q;
        unique case ({push_acc, pop_acc})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_acc) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/pic_bus_buffer_ctl.sv
// Host-side data bus buffer for the PIC: strobe synchronisers, write capture into a FIFO,
// and a request/hold read state machine with explicit bus-direction control.
module pic_bus_buffer_ctl
    import pic_bus_pkg::*;
#(
    parameter int unsigned DATA_W      = DefDataW,
    parameter int unsigned DEPTH       = DefDepth,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        cs_n_i,
    input  logic                        rd_n_i,
    input  logic                        wr_n_i,
    input  logic                        a0_i,
    input  logic [DATA_W-1:0]           d_i,
    output logic [DATA_W-1:0]           d_o,
    output logic                        d_oe_o,
    output logic                        wr_valid_o,
    output logic [DATA_W-1:0]           wr_data_o,
    output logic                        wr_a0_o,
    input  logic                        wr_ready_i,
    output logic                        rd_req_o,
    output logic                        rd_a0_o,
    input  logic [DATA_W-1:0]           rd_data_i,
    output logic [level_w(DEPTH)-1:0]   level_o,
    output logic                        ovf_o,
    input  logic                        ovf_clr_i
);

    // Each stage carries {real, cs, rd, wr}; "real" marks samples taken after reset release
    // so a strobe held low through reset never looks like a fresh edge.
    logic [3:0] sync_raw, sync_s;
    assign sync_raw = {1'b1, cs_n_i, rd_n_i, wr_n_i};

    for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_sync
        logic [3:0] q;
        logic [3:0] d;
        if (i == 0) begin : g_head
            assign d = sync_raw;
        end else begin : g_tail
            assign d = g_sync[i-1].q;
        end
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) q <= 4'b0111;
            else       q <= d;
        end
    end

    assign sync_s = g_sync[SYNC_STAGES-1].q;

    logic cs_s, rd_s, wr_s;
    logic vld_p_q, rd_p_q, wr_p_q;
    logic rd_fall, wr_fall, wr_rise;

    assign cs_s = sync_s[2];
    assign rd_s = sync_s[1];
    assign wr_s = sync_s[0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) {vld_p_q, rd_p_q, wr_p_q} <= 3'b011;
        else       {vld_p_q, rd_p_q, wr_p_q} <= {sync_s[3], rd_s, wr_s};
    end

    assign rd_fall = vld_p_q & rd_p_q & ~rd_s;
    assign wr_fall = vld_p_q & wr_p_q & ~wr_s;
    assign wr_rise = vld_p_q & ~wr_p_q & wr_s;

    // Write capture: shadow tracks the bus during a selected low phase, pushed on the rise.
    logic [DATA_W:0] shadow_q, shadow_d;
    logic            shadow_vld_q, shadow_vld_d;
    logic            wr_ph_q, wr_ph_d;
    logic            wr_load, push;
    logic            fifo_full, fifo_empty, pop;
    logic            ovf_q, ovf_d;

    assign wr_load = ~wr_s & ~cs_s & (wr_ph_q | wr_fall);
    assign push    = wr_rise & shadow_vld_q;
    assign pop     = wr_ready_i & ~fifo_empty;

    always_comb begin
        wr_ph_d      = wr_rise ? 1'b0 : (wr_fall ? 1'b1 : wr_ph_q);
        shadow_d     = wr_load ? {a0_i, d_i} : shadow_q;
        shadow_vld_d = wr_rise ? 1'b0 : (wr_load ? 1'b1 : shadow_vld_q);
        ovf_d        = (ovf_q & ~ovf_clr_i) | (push & fifo_full & ~pop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow_q     <= '0;
            shadow_vld_q <= 1'b0;
            wr_ph_q      <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            shadow_vld_q <= shadow_vld_d;
            wr_ph_q      <= wr_ph_d;
            ovf_q        <= ovf_d;
        end
    end

    pic_bus_wfifo #(
        .Width (DATA_W + 1),
        .Depth (DEPTH)
    ) u_wfifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (shadow_q),
        .pop_i   (pop),
        .data_o  ({wr_a0_o, wr_data_o}),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

    assign wr_valid_o = ~fifo_empty;
    assign ovf_o      = ovf_q;

    // Read FSM
    rd_state_e       state_q, state_d;
    logic [DATA_W-1:0] d_out_q, d_out_d;
    logic            rd_a0_q, rd_a0_d;

    always_comb begin
        state_d  = state_q;
        d_out_d  = d_out_q;
        rd_a0_d  = rd_a0_q;
        rd_req_o = 1'b0;
        d_oe_o   = 1'b0;
        unique case (state_q)
            R_IDLE: begin
                if (rd_fall & ~cs_s) begin
                    state_d = R_REQ;
                    rd_a0_d = a0_i;
                end
            end
            R_REQ: begin
                rd_req_o = 1'b1;
                d_out_d  = rd_data_i;
                state_d  = R_DRIVE;
            end
            R_DRIVE: begin
                // Never fight a host that is driving the bus for a write.
                d_oe_o = wr_s;
                if (rd_s | cs_s) state_d = R_IDLE;
            end
            default: state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= R_IDLE;
            d_out_q <= '0;
            rd_a0_q <= 1'b0;
        end else begin
            state_q <= state_d;
            d_out_q <= d_out_d;
            rd_a0_q <= rd_a0_d;
        end
    end

    assign d_o     = d_out_q;
    assign rd_a0_o = rd_a0_q;

endmodule

// File: tb/tb_pic_bus_buffer_ctl.sv
// Scoreboard bench for pic_bus_buffer_ctl: host writes/reads, FIFO overflow, reset and conflicts.
module tb_pic_bus_buffer_ctl;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned SYNC  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cs_n, rd_n, wr_n, a0;
    logic [DW-1:0] d_in, d_out, wr_data, rd_data;
    logic          d_oe, wr_valid, wr_a0, wr_ready, rd_req, rd_a0, ovf, ovf_clr;
    logic [2:0]    level;

    int total = 0;
    int bad   = 0;
    logic          exp_ovf;
    logic [DW:0]   wq[$];
    logic [DW-1:0] rq[$];

    always #5 clk = ~clk;

    pic_bus_buffer_ctl #(
        .DATA_W      (DW),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cs_n_i     (cs_n),
        .rd_n_i     (rd_n),
        .wr_n_i     (wr_n),
        .a0_i       (a0),
        .d_i        (d_in),
        .d_o        (d_out),
        .d_oe_o     (d_oe),
        .wr_valid_o (wr_valid),
        .wr_data_o  (wr_data),
        .wr_a0_o    (wr_a0),
        .wr_ready_i (wr_ready),
        .rd_req_o   (rd_req),
        .rd_a0_o    (rd_a0),
        .rd_data_i  (rd_data),
        .level_o    (level),
        .ovf_o      (ovf),
        .ovf_clr_i  (ovf_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Host write cycle; the model decides acceptance from its own queue depth.
    task automatic host_write(input logic a, input logic [DW-1:0] d);
        cs_n = 1'b0; a0 = a; d_in = d; wr_n = 1'b0;
        if (wq.size() < DEPTH) wq.push_back({a, d});
        else exp_ovf = 1'b1;
        repeat (2) tick();
        wr_n = 1'b1;
        repeat (SYNC + 1) tick();
    endtask

    task automatic drain(input string nm);
        logic [DW:0] exp;
        wr_ready = 1'b1;
        for (int n = 0; n < 16 && wq.size() > 0; n++) begin
            exp = wq.pop_front();
            total++;
            if (wr_valid !== 1'b1 || {wr_a0, wr_data} !== exp) begin
                bad++;
                $display("FAIL %s pop: got v=%b %h expected v=1 %h", nm, wr_valid,
                         {wr_a0, wr_data}, exp);
            end
            tick();
        end
        wr_ready = 1'b0;
        total++;
        if (level !== 3'd0 || wr_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s empty: got level=%0d v=%b expected 0 0", nm, level, wr_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; a0 = 1'b0; d_in = '0;
        wr_ready = 1'b0; rd_data = '0; ovf_clr = 1'b0; exp_ovf = 1'b0;
        repeat (3) tick();
        total++;
        if ({d_oe, d_out, rd_req, rd_a0, wr_valid, level, ovf} !== '0) begin
            bad++;
            $display("FAIL reset_state: got oe=%b dout=%h req=%b a0=%b v=%b lvl=%0d ovf=%b expected 0",
                     d_oe, d_out, rd_req, rd_a0, wr_valid, level, ovf);
        end
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_write_single();
        cs_n = 1'b0; a0 = 1'b1; d_in = 8'h13; wr_n = 1'b0;
        wq.push_back({1'b1, 8'h13});
        repeat (4) tick();
        wr_n = 1'b1;
        repeat (SYNC) tick();
        total++;
        if (wr_valid !== 1'b0) begin
            bad++;
            $display("FAIL write_early: got v=%b expected 0", wr_valid);
        end
        tick();
        total++;
        if (wr_valid !== 1'b1 || wr_data !== 8'h13 || wr_a0 !== 1'b1 || level !== 3'd1) begin
            bad++;
            $display("FAIL write_single: got v=%b d=%h a0=%b lvl=%0d expected 1 13 1 1",
                     wr_valid, wr_data, wr_a0, level);
        end
        drain("write_single");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) begin
            host_write(1'b0, 8'hA0 + 8'(i));
            if (i == 3) begin
                total++;
                if (level !== 3'd4 || ovf !== 1'b0) begin
                    bad++;
                    $display("FAIL full_no_ovf: got lvl=%0d ovf=%b expected 4 0", level, ovf);
                end
            end
        end
        total++;
        if (level !== 3'd4 || ovf !== exp_ovf) begin
            bad++;
            $display("FAIL overflow: got lvl=%0d ovf=%b expected 4 %b", level, ovf, exp_ovf);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        exp_ovf = 1'b0;
        total++;
        if (ovf !== exp_ovf) begin
            bad++;
            $display("FAIL ovf_clr: got ovf=%b expected 0", ovf);
        end
        drain("overflow");
    endtask

    task automatic test_full_pop();
        logic [DW:0] exp;
        for (int i = 0; i < 4; i++) host_write(1'b0, 8'hB0 + 8'(i));
        cs_n = 1'b0; a0 = 1'b1; d_in = 8'hB4; wr_n = 1'b0;
        repeat (2) tick();
        wr_n = 1'b1;
        repeat (SYNC) tick();
        // Push lands on the next edge; pop the head on that same edge.
        wr_ready = 1'b1;
        exp = wq.pop_front();
        total++;
        if (wr_valid !== 1'b1 || {wr_a0, wr_data} !== exp) begin
            bad++;
            $display("FAIL full_pop_head: got %h expected %h", {wr_a0, wr_data}, exp);
        end
        wq.push_back({1'b1, 8'hB4});
        tick();
        wr_ready = 1'b0;
        total++;
        if (level !== 3'd4 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL full_pop: got lvl=%0d ovf=%b expected 4 0", level, ovf);
        end
        drain("full_pop");
    endtask

    task automatic test_read(input logic a, input logic [DW-1:0] data);
        int req_cnt = 0, req_at = -1, oe_at = -1, fall_at = -1;
        logic [DW-1:0] exp;
        cs_n = 1'b0; a0 = a; rd_data = data; rd_n = 1'b0;
        rq.push_back(data);
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (rd_req) begin req_cnt++; if (req_at < 0) req_at = i; end
            if (d_oe && oe_at < 0) oe_at = i;
            if (i == SYNC + 2) begin a0 = ~a; rd_data = 8'hFF; end
        end
        exp = rq.pop_front();
        total++;
        if (req_cnt != 1 || req_at != SYNC + 1) begin
            bad++;
            $display("FAIL rd_req: got cnt=%0d at=%0d expected 1 %0d", req_cnt, req_at, SYNC + 1);
        end
        total++;
        if (oe_at != SYNC + 2 || d_oe !== 1'b1 || d_out !== exp || rd_a0 !== a) begin
            bad++;
            $display("FAIL read_drive: got oe_at=%0d oe=%b dout=%h a0=%b expected %0d 1 %h %b",
                     oe_at, d_oe, d_out, rd_a0, SYNC + 2, exp, a);
        end
        rd_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (!d_oe && fall_at < 0) fall_at = i;
        end
        total++;
        if (fall_at != SYNC + 1) begin
            bad++;
            $display("FAIL read_release: got %0d edges expected %0d", fall_at, SYNC + 1);
        end
    endtask

    task automatic test_rw_conflict();
        cs_n = 1'b0; a0 = 1'b1; rd_data = 8'h9A; rd_n = 1'b0;
        rq.push_back(8'h9A);
        repeat (SYNC + 2) tick();
        total++;
        if (d_oe !== 1'b1 || d_out !== rq.pop_front()) begin
            bad++;
            $display("FAIL conflict_drive: got oe=%b dout=%h expected 1 9a", d_oe, d_out);
        end
        d_in = 8'h77; wr_n = 1'b0;
        repeat (SYNC) tick();
        total++;
        if (d_oe !== 1'b0) begin
            bad++;
            $display("FAIL conflict_oe_gate: got oe=%b expected 0", d_oe);
        end
        wr_n = 1'b1;
        wq.push_back({1'b1, 8'h77});
        repeat (SYNC + 1) tick();
        total++;
        if (d_oe !== 1'b1 || level !== 3'd1) begin
            bad++;
            $display("FAIL conflict_push: got oe=%b lvl=%0d expected 1 1", d_oe, level);
        end
        rd_n = 1'b1;
        repeat (SYNC + 1) tick();
        total++;
        if (d_oe !== 1'b0) begin
            bad++;
            $display("FAIL conflict_release: got oe=%b expected 0", d_oe);
        end
        drain("conflict");
    endtask

    task automatic test_cs_high();
        int hits = 0;
        cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        repeat (SYNC + 2) tick();
        for (int i = 0; i < 24; i++) begin
            rd_n = 1'($urandom_range(0, 1));
            wr_n = (i % 3 == 0) ? 1'b0 : 1'b1;
            tick();
            if (rd_req !== 1'b0 || d_oe !== 1'b0 || level !== 3'd0) hits++;
        end
        rd_n = 1'b1; wr_n = 1'b1;
        repeat (SYNC + 2) tick();
        total++;
        if (hits != 0 || level !== 3'd0 || wr_valid !== 1'b0) begin
            bad++;
            $display("FAIL cs_high: got bad_cycles=%0d lvl=%0d v=%b expected 0 0 0",
                     hits, level, wr_valid);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        int hits = 0;
        host_write(1'b0, 8'h3C);
        cs_n = 1'b0; rd_data = 8'h11; rd_n = 1'b0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            tick();
            if (d_oe) seen = 1;
        end
        total++;
        if (seen != 1) begin
            bad++;
            $display("FAIL reset_mid_setup: got oe_seen=%0d expected 1", seen);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (d_oe !== 1'b0 || level !== 3'd0 || ovf !== 1'b0 || rd_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: got oe=%b lvl=%0d ovf=%b req=%b expected 0 0 0 0",
                     d_oe, level, ovf, rd_req);
        end
        wq.delete();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rd_req !== 1'b0 || d_oe !== 1'b0) hits++;
        end
        total++;
        if (hits != 0) begin
            bad++;
            $display("FAIL reset_release: got %0d cycles with req/oe expected 0", hits);
        end
        rd_n = 1'b1; cs_n = 1'b1;
        repeat (SYNC + 2) tick();
        total++;
        if (level !== 3'd0 || d_oe !== 1'b0) begin
            bad++;
            $display("FAIL reset_after: got lvl=%0d oe=%b expected 0 0", level, d_oe);
        end
    endtask

    initial begin
        test_reset();
        test_write_single();
        test_overflow();
        test_full_pop();
        test_read(1'b1, 8'hA5);
        test_read(1'b0, 8'h5C);
        test_rw_conflict();
        test_cs_high();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
